// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU: the operation select
// encoding and the default datapath width.
// ---------------------------------------------------------------------------
package alu_pkg;

  // Default datapath width in bits.
  localparam int ALU_WIDTH = 64;

  // Operation select codes. Codes 3'b001 and 3'b111 are unused and
  // produce a zero result.
  typedef enum logic [2:0] {
    ALU_PASS_B   = 3'b000,
    ALU_ADD      = 3'b010,
    ALU_SUBTRACT = 3'b011,
    ALU_AND      = 3'b100,
    ALU_OR       = 3'b101,
    ALU_XOR      = 3'b110
  } alu_cntrl_e;

endpackage

// File: rtl/alu_adder.sv
// ---------------------------------------------------------------------------
// alu_adder
// WIDTH-bit ripple-carry adder with a carry-in.
// Ports:
//   i_a, i_b         : addends
//   i_carryIn        : carry into bit 0
//   o_sum            : WIDTH-bit sum, wraps modulo 2^WIDTH
//   o_carryIntoMsb   : carry into bit WIDTH-1
//   o_carryOut       : carry out of bit WIDTH-1
// ---------------------------------------------------------------------------
module alu_adder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carryIn,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carryIntoMsb,
  output logic             o_carryOut
);

  // w_carry[i] is the carry into bit i; w_carry[WIDTH] leaves the MSB.
  logic [WIDTH:0] w_carry;

  assign w_carry[0] = i_carryIn;

  // One full-adder cell per bit, chained through w_carry.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fullAdder
    assign o_sum[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
    assign w_carry[i + 1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_carryIntoMsb = w_carry[WIDTH-1];
  assign o_carryOut     = w_carry[WIDTH];

endmodule

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Execute-stage integer ALU: pass-B, add, subtract, AND, OR, XOR.
// Result and status flags are registered (1-cycle latency); reset is
// synchronous and active-high.
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset
//   A, B      : operands
//   cntrl     : operation select (see alu_pkg::alu_cntrl_e)
//   result    : registered result
//   negative  : registered result MSB
//   zero      : registered, result is all zeros
//   overflow  : registered signed overflow (add/subtract only)
//   carry_out : registered carry out of MSB (add/subtract only;
//               for subtract, 1 means no borrow)
// ---------------------------------------------------------------------------
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrl,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  logic             w_sub;
  logic             w_isArith;
  logic [WIDTH-1:0] w_bOperand;
  logic [WIDTH-1:0] w_sum;
  logic             w_carryIntoMsb;
  logic             w_carryOut;
  logic [WIDTH-1:0] w_result;
  logic             w_overflow;
  logic             w_carryFlag;

  logic [WIDTH-1:0] r_result;
  logic             r_negative;
  logic             r_zero;
  logic             r_overflow;
  logic             r_carryOut;

  // Subtract reuses the adder as A + ~B + 1.
  assign w_sub      = (cntrl == ALU_SUBTRACT);
  assign w_isArith  = (cntrl == ALU_ADD) || w_sub;
  assign w_bOperand = B ^ {WIDTH{w_sub}};

  alu_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .i_a            (A),
    .i_b            (w_bOperand),
    .i_carryIn      (w_sub),
    .o_sum          (w_sum),
    .o_carryIntoMsb (w_carryIntoMsb),
    .o_carryOut     (w_carryOut)
  );

  // Result select; unused codes fall through to zero.
  always_comb begin
    w_result = '0;
    case (alu_cntrl_e'(cntrl))
      ALU_PASS_B:   w_result = B;
      ALU_ADD:      w_result = w_sum;
      ALU_SUBTRACT: w_result = w_sum;
      ALU_AND:      w_result = A & B;
      ALU_OR:       w_result = A | B;
      ALU_XOR:      w_result = A ^ B;
      default:      w_result = '0;
    endcase
  end

  // Signed overflow is the carry into the MSB disagreeing with the carry out.
  assign w_overflow  = w_isArith & (w_carryIntoMsb ^ w_carryOut);
  assign w_carryFlag = w_isArith & w_carryOut;

  // Output registers; reset discards whatever operation is on the inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result   <= '0;
      r_negative <= 1'b0;
      r_zero     <= 1'b1;
      r_overflow <= 1'b0;
      r_carryOut <= 1'b0;
    end else begin
      r_result   <= w_result;
      r_negative <= w_result[WIDTH-1];
      r_zero     <= (w_result == '0);
      r_overflow <= w_overflow;
      r_carryOut <= w_carryFlag;
    end
  end

  assign result    = r_result;
  assign negative  = r_negative;
  assign zero      = r_zero;
  assign overflow  = r_overflow;
  assign carry_out = r_carryOut;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu
// Self-checking bench for the 64-bit ALU: directed vector table, randomized
// operations against a behavioural model, and reset/latency sequences.
// ---------------------------------------------------------------------------
module tb_alu;
  import alu_pkg::*;

  localparam int W = 64;
  localparam logic signed [W:0] MAX_S = 65'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [W:0] MIN_S = -MAX_S - 65'sd1;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   cntrl;
  logic [W-1:0] result;
  logic         negative;
  logic         zero;
  logic         overflow;
  logic         carry_out;

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         n;
    logic         z;
    logic         v;
    logic         c;
  } vec_t;

  localparam int NUM_VECS = 17;
  vec_t vecs [NUM_VECS];

  alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .cntrl     (cntrl),
    .result    (result),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Behavioural reference: wide unsigned/signed arithmetic, range checks.
  task automatic refModel(input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, output logic [W-1:0] r,
                          output logic n, output logic z, output logic v,
                          output logic c);
    logic signed [W:0] sa;
    logic signed [W:0] sb;
    logic signed [W:0] sr;
    logic [W:0]        ur;
    sa = $signed({a[W-1], a});
    sb = $signed({b[W-1], b});
    r = '0; v = 1'b0; c = 1'b0;
    case (op)
      3'b000: r = b;
      3'b010: begin
        ur = {1'b0, a} + {1'b0, b};
        r  = ur[W-1:0];
        c  = ur[W];
        sr = sa + sb;
        v  = (sr > MAX_S) || (sr < MIN_S);
      end
      3'b011: begin
        r  = a - b;
        c  = (a >= b);
        sr = sa - sb;
        v  = (sr > MAX_S) || (sr < MIN_S);
      end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      default: r = '0;
    endcase
    n = r[W-1];
    z = (r == '0);
  endtask

  // Drive one cycle of inputs, clock it in, and settle just after the edge.
  task automatic applyStimulus(input logic rst, input logic [2:0] op,
                               input logic [W-1:0] a, input logic [W-1:0] b);
    reset = rst;
    cntrl = op;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] er,
                             input logic en, input logic ez, input logic ev,
                             input logic ec);
    testCount++;
    if ({result, negative, zero, overflow, carry_out} !== {er, en, ez, ev, ec}) begin
      failCount++;
      $display("[TB] FAIL %s: got r=%h n=%b z=%b v=%b c=%b, expected r=%h n=%b z=%b v=%b c=%b",
               name, result, negative, zero, overflow, carry_out, er, en, ez, ev, ec);
    end
  endtask

  task automatic randomCheck(input string name, input logic [2:0] op);
    logic [W-1:0] a, b, er;
    logic en, ez, ev, ec;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    if ($urandom_range(0, 15) == 0) b = '0;
    refModel(op, a, b, er, en, ez, ev, ec);
    applyStimulus(1'b0, op, a, b);
    checkOutput(name, er, en, ez, ev, ec);
  endtask

  initial begin
    vecs[0]  = '{3'b010, 64'h1, 64'h1, 64'h2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b010, 64'hC000000000000001, 64'hC000000000000001,
                 64'h8000000000000002, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{3'b010, 64'h2000000000000001, 64'h6000000000000001,
                 64'h8000000000000002, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{3'b010, 64'h7FFFFFFFFFFFFFFF, 64'h1,
                 64'h8000000000000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{3'b010, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                 64'hFFFFFFFFFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{3'b011, 64'h1, 64'h1, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{3'b011, 64'h2C, 64'h0D, 64'h1F, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{3'b011, 64'h0C, 64'h10, 64'hFFFFFFFFFFFFFFFC, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'b011, 64'h8000000000000000, 64'h7FFFFFFFFFFFFFFF,
                 64'h1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{3'b100, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555,
                 64'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{3'b101, 64'h2AAAAAAAAAAAAAAA, 64'h5555555555555555,
                 64'h7FFFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'b110, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555,
                 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{3'b110, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                 64'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{3'b000, 64'h123, 64'h8000000000000000,
                 64'h8000000000000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{3'b001, 64'h5, 64'h7, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{3'b111, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                 64'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{3'b011, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1};

    reset = 1'b1;
    cntrl = ALU_ADD;
    A     = 64'h7;
    B     = 64'h9;

    // Reset held for two cycles with live operands on the inputs.
    applyStimulus(1'b1, ALU_ADD, {$urandom, $urandom}, {$urandom, $urandom});
    checkOutput("reset_cycle1", 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, ALU_XOR, 64'hFFFFFFFFFFFFFFFF, 64'h1);
    checkOutput("reset_cycle2", 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Directed vector table.
    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(1'b0, vecs[i].op, vecs[i].a, vecs[i].b);
      checkOutput($sformatf("vec%0d", i), vecs[i].res, vecs[i].n, vecs[i].z,
                  vecs[i].v, vecs[i].c);
    end

    // Outputs hold between edges even when inputs change.
    applyStimulus(1'b0, ALU_ADD, 64'h3, 64'h4);
    cntrl = ALU_XOR;
    A = 64'hFFFFFFFFFFFFFFFF;
    B = 64'h0;
    #2;
    checkOutput("hold_between_edges", 64'h7, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized checks against the reference model.
    for (int i = 0; i < 100; i++) randomCheck($sformatf("pass_b_rand%0d", i), ALU_PASS_B);
    for (int i = 0; i < 100; i++) randomCheck($sformatf("sub_rand%0d", i), ALU_SUBTRACT);
    for (int i = 0; i < 100; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      randomCheck($sformatf("mixed_rand%0d_op%0d", i, op), op);
    end

    // Reset mid-stream: a nonzero result, then reset alongside ADD 1+1.
    applyStimulus(1'b0, ALU_ADD, 64'h3, 64'h4);
    checkOutput("pre_reset_add", 64'h7, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, ALU_ADD, 64'h1, 64'h1);
    checkOutput("reset_beats_add", 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, ALU_SUBTRACT, 64'h5, 64'h3);
    checkOutput("first_after_reset", 64'h2, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, ALU_OR, 64'hF0, 64'h0F);
    checkOutput("second_after_reset", 64'hFF, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
64-bit integer ALU for the datapath execute stage. It supports pass-B, add, subtract, AND, OR and XOR, selected by a 3-bit control code. It produces a 64-bit result and four status flags: negative, zero, overflow and carry_out. Inputs are combinational; result and flags are registered, so latency is 1 cycle.

Parameters:
WIDTH, 64, datapath width in bits; all arithmetic and flag rules below are written for WIDTH (default 64).

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
A  input  WIDTH  operand A
B  input  WIDTH  operand B
cntrl  input  3  operation select
result  output  WIDTH  registered operation result
negative  output  1  registered; result[WIDTH-1]
zero  output  1  registered; 1 when result is all zeros
overflow  output  1  registered; signed overflow on add/subtract
carry_out  output  1  registered; carry out of MSB on add/subtract

Behaviour:
- Opcodes:
  - 000 PASS_B: result=B
  - 010 ADD: A+B
  - 011 SUB: A-B
  - 100 AND: A&B
  - 101 OR: A|B
  - 110 XOR: A^B
  - 001 and 111 are unused: result=0.
- Timing: on each rising clk with reset=0, all outputs load values computed from the A, B and cntrl values sampled at that edge. Outputs change only on clock edges; there is no combinational path from inputs to outputs.
- Reset: on a rising clk with reset=1:
  - result=0, zero=1, negative=0, overflow=0, carry_out=0.
  - Reset has priority over any operation and discards the operation in flight.
  - The first valid result appears 1 cycle after reset deasserts.
- Adder: a single WIDTH-bit adder computes A + (B ^ {WIDTH{sub}}) + sub, where sub=1 for SUB.
  - Results wrap modulo 2^WIDTH.
- carry_out: the carry out of bit WIDTH-1 of that adder, for ADD and SUB.
  - For SUB this is the ARM convention: 1 = no borrow. Example: 1-1 gives carry_out=1.
- overflow: for ADD/SUB, 1 when the two adder operands (A and B-or-~B) have equal sign bits and the sum's sign differs. Equivalently, carry into MSB XOR carry out of MSB.
- overflow and carry_out are forced to 0 for PASS_B, AND, OR, XOR and unused codes.
- negative = result[WIDTH-1] and zero = (result==0) for every opcode, including PASS_B and the logic ops.
- Boundary cases:
  - 0x7FFF..FF+1 gives overflow=1.
  - 0x8000..00-0x7FFF..FF = 1 with overflow=1, carry_out=1.
  - All-ones + all-ones gives carry_out=1, overflow=0.
- A cntrl change between cycles has no side effects; each cycle is independent.

Decomposition:
- Shared package alu_pkg holds:
  - the cntrl typedef (3-bit enum): ALU_PASS_B=3'b000, ALU_ADD=3'b010, ALU_SUBTRACT=3'b011, ALU_AND=3'b100, ALU_OR=3'b101, ALU_XOR=3'b110
  - the WIDTH default constant.
- One sub-module, alu_adder: a WIDTH-bit adder with a carry-in. Its outputs are sum, carry into MSB and carry out of MSB. It is built as a ripple chain of full-adder bits.
- Top level handles the B inversion, logic ops, result mux, flag generation and output registers.

Test Plan:
- Reset: hold reset=1 for 2 cycles with any A/B -> result=0, zero=1, negative=0, overflow=0, carry_out=0.
- PASS_B with 100 random A/B -> one cycle later, result=B, negative=B[63], zero=(B==0), overflow=0, carry_out=0.
- ADD:
  - 1+1 -> 2, all flags 0.
  - 0xC000000000000001+0xC000000000000001 -> 0x8000000000000002, carry_out=1, overflow=0, negative=1.
  - 0x2000000000000001+0x6000000000000001 -> 0x8000000000000002, overflow=1, carry_out=0, negative=1.
- SUB:
  - 1-1 -> 0, zero=1, carry_out=1, overflow=0.
  - 0x2C-0x0D -> 0x1F, carry_out=1.
  - 0x0C-0x10 -> 0xFFFFFFFFFFFFFFFC, negative=1, carry_out=0, overflow=0.
  - 0x8000000000000000-0x7FFFFFFFFFFFFFFF -> 1, overflow=1, carry_out=1.
  - 100 random pairs -> result==A-B.
- Logic ops:
  - AND 0xAAAA..AA & 0x5555..55 -> 0, zero=1.
  - OR 0x2AAA..AA | 0x5555..55 -> 0x7FFF..FF, negative=0.
  - XOR 0xAAAA..AA ^ 0x5555..55 -> 0xFFFF..FF, negative=1.
  - XOR all-ones with itself -> 0, zero=1.
- Reset mid-stream: assert reset in the same cycle as an ADD of 1+1 -> next output is the reset value, not 2. After deassert, the next op's result appears 1 cycle later.
